// File: rtl/wb_rr_arbiter.sv
// Wishbone arbiter: NCHAN masters share one slave port. Arbitration is round-robin or
// fixed-priority, the owner keeps the bus while its cyc stays high, and an optional ack timeout applies.
module wb_rr_arbiter #(
  parameter int NCHAN   = 2,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int MODE    = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NCHAN-1:0]            m_cyc_i,
  input  logic [NCHAN-1:0]            m_stb_i,
  input  logic [NCHAN-1:0]            m_we_i,
  input  logic [NCHAN*AWIDTH-1:0]     m_adr_i,
  input  logic [NCHAN*DWIDTH-1:0]     m_dat_i,
  input  logic [NCHAN*(DWIDTH/8)-1:0] m_sel_i,
  output logic [DWIDTH-1:0]           m_dat_o,
  output logic [NCHAN-1:0]            m_ack_o,
  output logic [NCHAN-1:0]            m_err_o,
  output logic [NCHAN-1:0]            grant_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AWIDTH-1:0]           s_adr_o,
  output logic [DWIDTH-1:0]           s_dat_o,
  output logic [DWIDTH/8-1:0]         s_sel_o,
  input  logic [DWIDTH-1:0]           s_dat_i,
  input  logic                        s_ack_i
);

  localparam int SELW   = DWIDTH / 8;
  localparam int LW     = $clog2(NCHAN);
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLIM = CW'(TLIM_I);

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q, state_d;
  logic [NCHAN-1:0] grant_q, grant_d;
  logic [NCHAN-1:0] err_q, err_d;
  logic [LW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    win_idx;
  logic [LW-1:0]    scan_idx;
  logic             win_found;
  logic             stall;
  logic             expire;

  // Winner search over the current requests; round-robin starts one past the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    if (MODE == 1) begin
      for (int k = 1; k <= NCHAN; k++) begin
        scan_idx = LW'((int'(last_q) + k) % NCHAN);
        if (!win_found && m_cyc_i[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        scan_idx = LW'(k);
        if (!win_found && m_cyc_i[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end
  end

  // Slave-side AND-OR mux: with no grant every term is zero.
  logic [NCHAN:0][AWIDTH-1:0] adr_acc;
  logic [NCHAN:0][DWIDTH-1:0] dat_acc;
  logic [NCHAN:0][SELW-1:0]   sel_acc;
  logic [NCHAN:0]             we_acc;

  assign adr_acc[0] = '0;
  assign dat_acc[0] = '0;
  assign sel_acc[0] = '0;
  assign we_acc[0]  = 1'b0;

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_mux
    assign adr_acc[gi+1] = adr_acc[gi] | (m_adr_i[gi*AWIDTH +: AWIDTH] & {AWIDTH{grant_q[gi]}});
    assign dat_acc[gi+1] = dat_acc[gi] | (m_dat_i[gi*DWIDTH +: DWIDTH] & {DWIDTH{grant_q[gi]}});
    assign sel_acc[gi+1] = sel_acc[gi] | (m_sel_i[gi*SELW +: SELW] & {SELW{grant_q[gi]}});
    assign we_acc[gi+1]  = we_acc[gi] | (m_we_i[gi] & grant_q[gi]);
  end

  assign s_adr_o = adr_acc[NCHAN];
  assign s_dat_o = dat_acc[NCHAN];
  assign s_sel_o = sel_acc[NCHAN];
  assign s_we_o  = we_acc[NCHAN];
  assign s_cyc_o = |(m_cyc_i & grant_q);
  assign s_stb_o = |(m_stb_i & grant_q);

  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant_q & {NCHAN{s_ack_i}};
  assign m_err_o = err_q;
  assign grant_o = grant_q;

  // A simultaneous ack suppresses expiry because stall requires no ack.
  assign stall  = s_stb_o & ~s_ack_i;
  assign expire = (TIMEOUT > 0) && (state_q == OWN) && stall && (cnt_q == TLIM);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = OWN;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
        end
      end
      OWN: begin
        if (expire) begin
          // Forced release: the next arbitration happens from IDLE one edge later.
          err_d   = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else if (!m_cyc_i[last_q]) begin
          grant_d = '0;
          if (win_found) begin
            grant_d[win_idx] = 1'b1;
            last_d           = win_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    cnt_d = cnt_q;
    if ((TIMEOUT == 0) || s_ack_i || (grant_d != grant_q)) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NCHAN - 1);
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: a round-robin instance with TIMEOUT=5 and a fixed-priority instance,
// driven from per-cycle vector tables through a scoreboard, plus an async-reset sequence.
module tb_wb_rr_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    rr_cyc, fp_cyc, we;
  logic [N*32-1:0] adr, wdat;
  logic [N*4-1:0]  sel;
  logic [31:0]     sdat;
  logic            rr_ack, fp_ack;

  logic [31:0]  rr_mdat, fp_mdat, rr_sadr, fp_sadr, rr_sdat, fp_sdat;
  logic [N-1:0] rr_mack, fp_mack, rr_merr, fp_merr, rr_grant, fp_grant;
  logic         rr_scyc, fp_scyc, rr_sstb, fp_sstb, rr_swe, fp_swe;
  logic [3:0]   rr_ssel, fp_ssel;

  wb_rr_arbiter #(.NCHAN(N), .AWIDTH(32), .DWIDTH(32), .MODE(1), .TIMEOUT(5)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m_cyc_i(rr_cyc), .m_stb_i(rr_cyc), .m_we_i(we),
    .m_adr_i(adr), .m_dat_i(wdat), .m_sel_i(sel),
    .m_dat_o(rr_mdat), .m_ack_o(rr_mack), .m_err_o(rr_merr), .grant_o(rr_grant),
    .s_cyc_o(rr_scyc), .s_stb_o(rr_sstb), .s_we_o(rr_swe),
    .s_adr_o(rr_sadr), .s_dat_o(rr_sdat), .s_sel_o(rr_ssel),
    .s_dat_i(sdat), .s_ack_i(rr_ack)
  );

  wb_rr_arbiter #(.NCHAN(N), .AWIDTH(32), .DWIDTH(32), .MODE(0), .TIMEOUT(0)) dut_fp (
    .clk_i(clk), .rst_i(rst_n),
    .m_cyc_i(fp_cyc), .m_stb_i(fp_cyc), .m_we_i(we),
    .m_adr_i(adr), .m_dat_i(wdat), .m_sel_i(sel),
    .m_dat_o(fp_mdat), .m_ack_o(fp_mack), .m_err_o(fp_merr), .grant_o(fp_grant),
    .s_cyc_o(fp_scyc), .s_stb_o(fp_sstb), .s_we_o(fp_swe),
    .s_adr_o(fp_sadr), .s_dat_o(fp_sdat), .s_sel_o(fp_ssel),
    .s_dat_i(sdat), .s_ack_i(fp_ack)
  );

  typedef struct {
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] grant;
    logic [3:0] mack;
    logic [3:0] err;
    logic       scyc;
  } vec_t;

  typedef struct {
    bit         fp;
    int         row;
    logic [3:0] grant;
    logic [3:0] mack;
    logic [3:0] err;
    logic       scyc;
    logic [31:0] sadr;
    logic [31:0] mdat;
  } exp_t;

  vec_t rr_tab[$];
  vec_t fp_tab[$];
  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  function automatic vec_t v(input logic [3:0] cyc, input logic ack, input logic [3:0] grant,
                             input logic [3:0] mack, input logic [3:0] err, input logic scyc);
    vec_t t;
    t.cyc = cyc; t.ack = ack; t.grant = grant; t.mack = mack; t.err = err; t.scyc = scyc;
    return t;
  endfunction

  // Each master's address is 0x100*(i+1); the slave sees the owner's address, else zero.
  function automatic logic [31:0] exp_adr(input logic [3:0] g);
    case (g)
      4'b0001: return 32'h100;
      4'b0010: return 32'h200;
      4'b0100: return 32'h300;
      4'b1000: return 32'h400;
      default: return 32'h0;
    endcase
  endfunction

  task automatic apply(input bit fp, input int row, input vec_t t);
    exp_t e;
    @(posedge clk);
    #1;
    sdat = 32'hD00D_0000 | 32'(row);
    if (fp) begin
      fp_cyc = t.cyc; fp_ack = t.ack; rr_cyc = '0; rr_ack = 1'b0;
    end else begin
      rr_cyc = t.cyc; rr_ack = t.ack; fp_cyc = '0; fp_ack = 1'b0;
    end
    e.fp = fp; e.row = row; e.grant = t.grant; e.mack = t.mack; e.err = t.err; e.scyc = t.scyc;
    e.sadr = exp_adr(t.grant);
    e.mdat = 32'hD00D_0000 | 32'(row);
    sb.push_back(e);
  endtask

  exp_t        me;
  string       pfx;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me  = sb.pop_front();
      pfx = $sformatf("%s[%0d]", me.fp ? "fp" : "rr", me.row);
      chk({pfx, " grant"}, me.fp ? 32'(fp_grant) : 32'(rr_grant), 32'(me.grant));
      chk({pfx, " m_ack"}, me.fp ? 32'(fp_mack)  : 32'(rr_mack),  32'(me.mack));
      chk({pfx, " m_err"}, me.fp ? 32'(fp_merr)  : 32'(rr_merr),  32'(me.err));
      chk({pfx, " s_cyc"}, me.fp ? 32'(fp_scyc)  : 32'(rr_scyc),  32'(me.scyc));
      chk({pfx, " s_adr"}, me.fp ? fp_sadr : rr_sadr, me.sadr);
      chk({pfx, " m_dat"}, me.fp ? fp_mdat : rr_mdat, me.mdat);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    // Round-robin instance: single master, rotation, burst lock, timeout, ack on the 5th edge.
    rr_tab.push_back(v(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1));
    rr_tab.push_back(v(4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b1111, 1, 4'b0010, 4'b0010, 4'b0000, 1));
    rr_tab.push_back(v(4'b1101, 0, 4'b0010, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b1101, 1, 4'b0100, 4'b0100, 4'b0000, 1));
    rr_tab.push_back(v(4'b1001, 0, 4'b0100, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b1001, 1, 4'b1000, 4'b1000, 4'b0000, 1));
    rr_tab.push_back(v(4'b0001, 0, 4'b1000, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1));
    rr_tab.push_back(v(4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0011, 1, 4'b0010, 4'b0010, 4'b0000, 1));
    rr_tab.push_back(v(4'b0011, 1, 4'b0010, 4'b0010, 4'b0000, 1));
    rr_tab.push_back(v(4'b0011, 0, 4'b0010, 4'b0000, 4'b0000, 1));
    rr_tab.push_back(v(4'b0011, 1, 4'b0010, 4'b0010, 4'b0000, 1));
    rr_tab.push_back(v(4'b0011, 1, 4'b0010, 4'b0010, 4'b0000, 1));
    rr_tab.push_back(v(4'b0001, 0, 4'b0010, 4'b0000, 4'b0000, 0));
    repeat (5) rr_tab.push_back(v(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1));
    rr_tab.push_back(v(4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 0));
    repeat (4) rr_tab.push_back(v(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1));
    rr_tab.push_back(v(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1));
    rr_tab.push_back(v(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1));
    rr_tab.push_back(v(4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 0));
    rr_tab.push_back(v(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0));

    // Fixed-priority instance: lowest index wins, the lock holds, and there is no timeout.
    fp_tab.push_back(v(4'b0101, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    fp_tab.push_back(v(4'b0101, 1, 4'b0001, 4'b0001, 4'b0000, 1));
    fp_tab.push_back(v(4'b0100, 0, 4'b0001, 4'b0000, 4'b0000, 0));
    fp_tab.push_back(v(4'b0101, 1, 4'b0100, 4'b0100, 4'b0000, 1));
    fp_tab.push_back(v(4'b1001, 0, 4'b0100, 4'b0000, 4'b0000, 0));
    fp_tab.push_back(v(4'b1001, 1, 4'b0001, 4'b0001, 4'b0000, 1));
    fp_tab.push_back(v(4'b1000, 0, 4'b0001, 4'b0000, 4'b0000, 0));
    repeat (6) fp_tab.push_back(v(4'b1000, 0, 4'b1000, 4'b0000, 4'b0000, 1));
    fp_tab.push_back(v(4'b1000, 1, 4'b1000, 4'b1000, 4'b0000, 1));
    fp_tab.push_back(v(4'b0000, 0, 4'b1000, 4'b0000, 4'b0000, 0));
    fp_tab.push_back(v(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0));

    rst_n  = 1'b0;
    rr_cyc = '0; fp_cyc = '0; rr_ack = 1'b0; fp_ack = 1'b0;
    we     = 4'b1010;
    adr    = {32'h400, 32'h300, 32'h200, 32'h100};
    wdat   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    sel    = 16'hFFFF;
    sdat   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < rr_tab.size(); i++) apply(1'b0, i, rr_tab[i]);
    for (int i = 0; i < fp_tab.size(); i++) apply(1'b1, i, fp_tab[i]);
    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset during m1's stalled strobe, then m0 must win first.
    @(posedge clk);
    #1 rr_cyc = 4'b0010; rr_ack = 1'b0; fp_cyc = '0; fp_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("rst pre grant", 32'(rr_grant), 32'h2);
    chk("rst pre s_cyc", 32'(rr_scyc), 32'h1);
    #1 rst_n = 1'b0;
    #1 rr_ack = 1'b1;
    #1;
    chk("rst grant", 32'(rr_grant), 32'h0);
    chk("rst s_cyc", 32'(rr_scyc), 32'h0);
    chk("rst m_ack", 32'(rr_mack), 32'h0);
    chk("rst m_err", 32'(rr_merr), 32'h0);
    rr_ack = 1'b0;
    rr_cyc = 4'b0011;
    @(posedge clk);
    #1;
    chk("rst hold grant", 32'(rr_grant), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst grant", 32'(rr_grant), 32'h1);
    chk("post-rst s_adr", rr_sadr, 32'h100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
